// File: rtl/vram_blitter_pkg.sv
// Shared constants for the VRAM fill/copy engine: state encoding, op codes and default widths.
package vram_blitter_pkg;

  localparam int unsigned BLT_ADDR_WIDTH = 15;
  localparam int unsigned BLT_DATA_WIDTH = 8;
  localparam int unsigned BLT_LEN_WIDTH  = 16;

  localparam logic [2:0] BLT_IDLE    = 3'd0;
  localparam logic [2:0] BLT_FILL    = 3'd1;
  localparam logic [2:0] BLT_CP_RD   = 3'd2;
  localparam logic [2:0] BLT_CP_WAIT = 3'd3;
  localparam logic [2:0] BLT_CP_WR   = 3'd4;
  localparam logic [2:0] BLT_DONE    = 3'd5;

  localparam logic BLT_OP_FILL = 1'b0;
  localparam logic BLT_OP_COPY = 1'b1;

  function automatic logic blt_is_busy(input logic [2:0] state);
    return (state == BLT_FILL) || (state == BLT_CP_RD) ||
           (state == BLT_CP_WAIT) || (state == BLT_CP_WR);
  endfunction

endpackage

// File: rtl/vram_blit_addr_gen.sv
// Address pointer with load and single-step increment/decrement; wraps modulo 2^ADDR_WIDTH.
module vram_blit_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic                  i_step,
  input  logic                  i_down,
  output logic [ADDR_WIDTH-1:0] o_ptr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_addr;
    end else if (i_step) begin
      r_ptr <= i_down ? (r_ptr - ONE) : (r_ptr + ONE);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/vram_blitter.sv
// Fill/copy engine driving VRAM port B; one access per granted cycle, memmove-safe copies.
module vram_blitter
  import vram_blitter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BLT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BLT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = BLT_LEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_op,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [DATA_WIDTH-1:0] i_fill_val,
  input  logic                  i_abort,
  input  logic                  i_port_free,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  logic [2:0]            r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [DATA_WIDTH-1:0] r_fill;
  logic                  r_down;

  logic                  w_load, w_step_src, w_step_dst, w_back;
  logic [ADDR_WIDTH-1:0] w_len_addr, w_src_load, w_dst_load, w_src_ptr, w_dst_ptr;

  // Overlap with dst above src must run backward from the last byte so no source is clobbered.
  assign w_back     = (i_op == BLT_OP_COPY) && (i_dst_addr > i_src_addr);
  assign w_len_addr = ADDR_WIDTH'(i_len);
  assign w_src_load = w_back ? (i_src_addr + w_len_addr - ADDR_ONE) : i_src_addr;
  assign w_dst_load = w_back ? (i_dst_addr + w_len_addr - ADDR_ONE) : i_dst_addr;

  vram_blit_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_ptr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_addr (w_src_load),
    .i_step      (w_step_src),
    .i_down      (r_down),
    .o_ptr       (w_src_ptr)
  );

  vram_blit_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_ptr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_addr (w_dst_load),
    .i_step      (w_step_dst),
    .i_down      (r_down),
    .o_ptr       (w_dst_ptr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_load      = 1'b0;
    w_step_src  = 1'b0;
    w_step_dst  = 1'b0;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_din   = '0;
    case (r_state)
      BLT_IDLE: begin
        if (i_start) begin
          w_load    = 1'b1;
          w_cnt_nxt = i_len;
          if (i_len == '0)              w_state_nxt = BLT_DONE;
          else if (i_op == BLT_OP_FILL) w_state_nxt = BLT_FILL;
          else                          w_state_nxt = BLT_CP_RD;
        end
      end
      BLT_FILL: begin
        if (i_abort) begin
          w_state_nxt = BLT_IDLE;
        end else if (i_port_free) begin
          o_ram_en    = 1'b1;
          o_ram_we    = 1'b1;
          o_ram_addr  = w_dst_ptr;
          o_ram_din   = r_fill;
          w_step_dst  = 1'b1;
          w_cnt_nxt   = r_cnt - LEN_ONE;
          if (r_cnt == LEN_ONE) w_state_nxt = BLT_DONE;
        end
      end
      BLT_CP_RD: begin
        if (i_abort) begin
          w_state_nxt = BLT_IDLE;
        end else if (i_port_free) begin
          o_ram_en    = 1'b1;
          o_ram_addr  = w_src_ptr;
          w_state_nxt = BLT_CP_WAIT;
        end
      end
      BLT_CP_WAIT: begin
        if (i_abort) begin
          w_state_nxt = BLT_IDLE;
        end else begin
          w_data_nxt  = i_ram_dout;
          w_state_nxt = BLT_CP_WR;
        end
      end
      BLT_CP_WR: begin
        if (i_abort) begin
          w_state_nxt = BLT_IDLE;
        end else if (i_port_free) begin
          o_ram_en    = 1'b1;
          o_ram_we    = 1'b1;
          o_ram_addr  = w_dst_ptr;
          o_ram_din   = r_data;
          w_step_src  = 1'b1;
          w_step_dst  = 1'b1;
          w_cnt_nxt   = r_cnt - LEN_ONE;
          w_state_nxt = (r_cnt == LEN_ONE) ? BLT_DONE : BLT_CP_RD;
        end
      end
      BLT_DONE: w_state_nxt = BLT_IDLE;
      default:  w_state_nxt = BLT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BLT_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= '0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      if (w_load) begin
        r_fill <= i_fill_val;
        r_down <= w_back;
      end
    end
  end

  assign o_busy = blt_is_busy(r_state);
  assign o_done = (r_state == BLT_DONE);

endmodule

// File: doc/vram_blitter.md
Name: vram_blitter

Overview:
- Fill/copy engine that sequences one port of the dual-port video RAM (port B); port A stays on the display fetch path.
- Register-file logic programs source, destination, length, fill value and op, then pulses start.
- Engine issues one RAM access per granted cycle.
- Host CPU accesses to the same port take priority through an external port_free grant.

Parameters:
- ADDR_WIDTH, 15, video RAM address width (matches VIDEO_RAM_WIDTH).
- DATA_WIDTH, 8, RAM data width.
- LEN_WIDTH, 16, transfer length counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches an operation; ignored unless idle.
- op  in  1  0 = fill, 1 = copy; sampled with start.
- src_addr  in  ADDR_WIDTH  copy source start address; sampled with start.
- dst_addr  in  ADDR_WIDTH  destination start address; sampled with start.
- len  in  LEN_WIDTH  byte count; sampled with start.
- fill_val  in  DATA_WIDTH  fill byte; sampled with start.
- abort  in  1  terminates the current operation.
- port_free  in  1  RAM port granted to the engine this cycle.
- busy  out  1  high from the cycle after an accepted start until the op ends.
- done  out  1  one-cycle pulse on completion.
- ram_en  out  1  engine drives an access this cycle.
- ram_we  out  1  write strobe.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  write data.
- ram_dout  in  DATA_WIDTH  RAM read data, valid one cycle after the read address.

Behaviour:
- Reset values: every output and internal register is 0; state is IDLE.
- States: IDLE, FILL, CP_RD, CP_WAIT, CP_WR, DONE.
- IDLE:
  - start=1 latches all inputs.
  - len=0: go to DONE.
  - op=0: go to FILL.
  - op=1: go to CP_RD.
- FILL:
  - When port_free=1: ram_en=ram_we=1, ram_addr=dst pointer, ram_din=latched fill_val.
  - On that edge the pointer advances and the remaining count decrements.
  - On the last write, go to DONE.
  - port_free=0: outputs low, nothing advances.
  - Throughput: 1 byte/cycle.
- Copy direction (memmove semantics):
  - Forward (pointers increment) when dst_addr <= src_addr.
  - Backward when dst_addr > src_addr; both pointers start at addr+len-1 (mod 2^ADDR_WIDTH) and decrement.
- CP_RD: when port_free=1, ram_en=1, ram_we=0, ram_addr=src pointer; go to CP_WAIT. Otherwise stall.
- CP_WAIT: no access; capture ram_dout into the data register; go to CP_WR.
- CP_WR:
  - When port_free=1: write the data register to the dst pointer, advance both pointers, decrement the count.
  - Next state is CP_RD, or DONE after the last byte.
  - Minimum 3 cycles/byte.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- busy=1 in FILL, CP_RD, CP_WAIT and CP_WR only.
- Address arithmetic is modulo 2^ADDR_WIDTH; 0x7FFF+1 wraps to 0x0000 at default width.
- len > 2^ADDR_WIDTH is legal; the addresses keep wrapping.
- abort=1 in any busy state: IDLE at the next edge, no done pulse, no access issued that cycle.
  - abort has priority over port_free.
  - abort in IDLE or DONE has no effect; a pending done still pulses.
- start while busy or in DONE is ignored; the latched parameters are unchanged.
- start and abort together in IDLE: start wins.
- rst asserted mid-operation: immediately IDLE; ram_en and ram_we drop asynchronously.
- Outputs are combinational from registered state plus port_free. No combinational path from start, op or addresses to the RAM outputs.

Decomposition:
- Shared package holds:
  - state encoding constants (BLT_IDLE..BLT_DONE);
  - op codes BLT_OP_FILL=0 and BLT_OP_COPY=1;
  - default widths.
- One natural sub-module: vram_blit_addr_gen. It holds a pointer with load, increment or decrement, and modulo wrap; it is instantiated twice (src and dst).

Test Plan:
- Fill, port_free=1, dst=0x0100, len=4, val=0xA5 -> writes 0x0100..0x0103=A5 on the 4 cycles after start; done in cycle 5; busy high for cycles 1-4.
- Forward copy, src=0x0200 (11 22 33), dst=0x0100, len=3 -> 0x0100..0x0102 = 11 22 33; access pattern RD, idle, WR per byte; done after 9 busy cycles.
- Overlapping copy, src=0x0300 (AA BB CC), dst=0x0301, len=3 -> backward order; result 0x0301..0x0303 = AA BB CC; 0x0300 unchanged.
- Wrap fill, dst=0x7FFE, len=4 -> writes 7FFE, 7FFF, 0000, 0001.
- port_free toggled 1,0,0,1... during fill len=2 -> no access while 0; exactly 2 writes; done follows the second granted write.
- len=0 -> done one cycle after start, no ram_en. Abort during CP_WAIT -> IDLE, no done, no further writes. Start during busy -> ignored. rst mid-fill -> outputs 0 without waiting for a clock edge.
